scan_master: RTL and testbench
==============================

Name: scan_master

Overview:
- Tester-side driver for the chip's two-phase scan interface: generates the non-overlapping phi/phib clocks and drives scan_i0o1, load and scan_in, while capturing scan_out.
- Implements both halves of the protocol: write (shift a word in, then pulse load) and read (capture chip state, then shift it out).
- Sits in the FPGA/bench harness opposite the chip's scan pads; a host issues one operation at a time through a start/done handshake.

Parameters:
- CHAIN_LEN, 64, scan chain length in bits (>=2).
- PHASE_CYC, 4, clk_signal_ext cycles per phase segment (>=2).

Ports:
- clk_signal_ext  in  1  system clock; every output is registered on it.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle operation request, sampled only in IDLE.
- rd_op  in  1  sampled with start: 0 = write, 1 = read.
- wdata  in  CHAIN_LEN  word to shift in; latched at start.
- rdata  out  CHAIN_LEN  word shifted out by the last read.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at operation end.
- phi  out  1  scan phase-1 clock.
- phib  out  1  scan phase-2 clock.
- scan_i0o1  out  1  1 = capture chip state into the chain.
- load  out  1  latch chain contents into chip shadow registers.
- scan_in  out  1  serial data to chip.
- scan_out  in  1  serial data from chip; passes through a 2-flop synchronizer.

Behaviour:
- Reset (async, all outputs): phi=phib=scan_i0o1=load=scan_in=0, busy=done=0, rdata=0, FSM=IDLE. Reset mid-operation aborts immediately; no partial phi/phib pulse survives.
- Bit period = 4 segments of PHASE_CYC cycles each:
  - S0: setup; scan_in updates on its first cycle; synchronized scan_out is sampled on its last cycle.
  - S1: phi=1.
  - S2: gap.
  - S3: phib=1.
- phi and phib are never high together; the gap between them is always >= PHASE_CYC cycles.
- States: IDLE, CAPTURE, SHIFT, LOAD_SU, LOAD_HI, LOAD_HD, DONE.
- IDLE:
  - start=1 latches wdata into the shift register and rd_op.
  - Next state is CAPTURE if rd_op=1, else SHIFT.
  - busy rises the next cycle.
- CAPTURE (read only):
  - One bit period with scan_i0o1=1 and scan_in=0; no sampling.
  - scan_i0o1 drops on the first cycle of the next state.
- SHIFT:
  - CHAIN_LEN bit periods with scan_i0o1=0.
  - Bit k (k=0 first) drives wdata[CHAIN_LEN-1-k].
  - On a read, the sample taken in bit k goes to rdata_shadow[CHAIN_LEN-1-k].
- Write path after SHIFT: LOAD_SU (PHASE_CYC cycles, load=0) -> LOAD_HI (load=1, PHASE_CYC cycles) -> LOAD_HD (load=0, PHASE_CYC cycles) -> DONE.
- Read path after SHIFT: goes straight to DONE. rdata <= rdata_shadow in the DONE cycle; write operations never modify rdata.
- DONE:
  - One cycle with done=1 and busy=0.
  - Returns to IDLE; start is sampled again from the cycle after DONE.
- Latency, start cycle -> done cycle:
  - write: CHAIN_LEN*4*PHASE_CYC + 3*PHASE_CYC + 1
  - read: (CHAIN_LEN+1)*4*PHASE_CYC + 1
- start while busy or in DONE is ignored (no queueing). rd_op/wdata changes during an operation have no effect.
- Counters: segment counter width $clog2(PHASE_CYC), bit counter width $clog2(CHAIN_LEN+1). Both wrap to 0 at terminal count; there are no off-by-one extra pulses.
- scan_in is held at the last driven value through the LOAD states, then returns to 0 in DONE.

Test Plan:
- Write, CHAIN_LEN=8, PHASE_CYC=2, wdata=8'hA5 against a behavioural chip chain model -> 8 phi and 8 phib pulses of 2 cycles each, non-overlapping. Model shadow register = 8'hA5 after a single 2-cycle load pulse. done exactly 71 cycles after start.
- Read with model state 8'h3C -> scan_i0o1 high for the first 8-cycle bit period, then 8 shift periods. rdata=8'h3C at done, 73 cycles after start. busy low at done.
- Back-to-back write 8'hFF then read -> read returns 8'hFF. A start pulsed during the first operation is ignored: exactly two done pulses.
- Assertion across all tests: phi&phib never 1; every phi/phib/load high time equals PHASE_CYC.
- Async reset asserted mid-SHIFT (bit 3, during phi high) -> phi, scan_in, busy go to 0 without waiting for a clock edge. rdata stays 0. A new write after reset completes with correct data.
- Write with CHAIN_LEN=64, PHASE_CYC=4, wdata=64'h0123_4567_89AB_CDEF, then read -> rdata equals wdata. Write latency 1037 cycles, read latency 1041 cycles.

Source files
------------

// File: rtl/scan_master_if.sv
// Tester-side scan bundle: host start/done handshake plus the two-phase scan pads.
// The master modport belongs to scan_master; the slave modport is the host/chip side.
interface scan_master_if #(
   parameter int CHAIN_LEN = 64
) ();
   logic                 start;
   logic                 rd_op;
   logic [CHAIN_LEN-1:0] wdata;
   logic [CHAIN_LEN-1:0] rdata;
   logic                 busy;
   logic                 done;
   logic                 phi;
   logic                 phib;
   logic                 scan_i0o1;
   logic                 load;
   logic                 scan_in;
   logic                 scan_out;

   modport master (
      input  start, rd_op, wdata, scan_out,
      output rdata, busy, done, phi, phib, scan_i0o1, load, scan_in
   );

   modport slave (
      output start, rd_op, wdata, scan_out,
      input  rdata, busy, done, phi, phib, scan_i0o1, load, scan_in
   );
endinterface

// File: rtl/scan_master.sv
// Two-phase scan driver: shifts a word into the chip chain and pulses load (write),
// or captures chip state and shifts it out into rdata (read).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; wdata/rd_op latched on acceptance
// CAPTURE  | one bit period with scan_i0o1=1 (read only)
// SHIFT    | CHAIN_LEN bit periods, MSB of the word first
// LOAD_SU  | load setup, PHASE_CYC cycles, load=0
// LOAD_HI  | load pulse, PHASE_CYC cycles, load=1
// LOAD_HD  | load hold, PHASE_CYC cycles, load=0
// DONE     | one-cycle done pulse; rdata updated on reads
module scan_master #(
   parameter int CHAIN_LEN = 64,
   parameter int PHASE_CYC = 4
) (
   input  logic          clk_signal_ext,
   input  logic          rst_n,
   scan_master_if.master bus
);

   localparam int SEG_W = $clog2(PHASE_CYC);
   localparam int BIT_W = $clog2(CHAIN_LEN + 1);
   localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(PHASE_CYC - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);

   localparam logic [1:0] PH_SETUP = 2'd0;
   localparam logic [1:0] PH_PHI   = 2'd1;
   localparam logic [1:0] PH_PHIB  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_SHIFT,
      ST_LOAD_SU,
      ST_LOAD_HI,
      ST_LOAD_HD,
      ST_DONE
   } state_t;

   state_t               state_q,  state_d;
   logic [SEG_W-1:0]     seg_q,    seg_d;
   logic [1:0]           ph_q,     ph_d;
   logic [BIT_W-1:0]     bit_q,    bit_d;
   logic                 rd_q,     rd_d;
   logic [CHAIN_LEN-1:0] wreg_q,   wreg_d;
   logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
   logic [CHAIN_LEN-1:0] rdata_q,  rdata_d;
   logic [1:0]           sync_q;
   logic                 busy_q,   busy_d;
   logic                 done_q,   done_d;
   logic                 phi_q,    phi_d;
   logic                 phib_q,   phib_d;
   logic                 i0o1_q,   i0o1_d;
   logic                 load_q,   load_d;
   logic                 scan_in_q, scan_in_d;

   logic seg_end;
   logic bit_end;
   logic bit_start;

   always_ff @(posedge clk_signal_ext or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         seg_q     <= '0;
         ph_q      <= PH_SETUP;
         bit_q     <= '0;
         rd_q      <= 1'b0;
         wreg_q    <= '0;
         shadow_q  <= '0;
         rdata_q   <= '0;
         sync_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         phi_q     <= 1'b0;
         phib_q    <= 1'b0;
         i0o1_q    <= 1'b0;
         load_q    <= 1'b0;
         scan_in_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_q     <= seg_d;
         ph_q      <= ph_d;
         bit_q     <= bit_d;
         rd_q      <= rd_d;
         wreg_q    <= wreg_d;
         shadow_q  <= shadow_d;
         rdata_q   <= rdata_d;
         sync_q    <= {sync_q[0], bus.scan_out};
         busy_q    <= busy_d;
         done_q    <= done_d;
         phi_q     <= phi_d;
         phib_q    <= phib_d;
         i0o1_q    <= i0o1_d;
         load_q    <= load_d;
         scan_in_q <= scan_in_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      seg_d     = seg_q;
      ph_d      = ph_q;
      bit_d     = bit_q;
      rd_d      = rd_q;
      wreg_d    = wreg_q;
      shadow_d  = shadow_q;
      rdata_d   = rdata_q;
      scan_in_d = scan_in_q;
      seg_end   = (seg_q == SEG_LAST);
      bit_end   = seg_end && (ph_q == PH_PHIB);

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               rd_d    = bus.rd_op;
               wreg_d  = bus.wdata;
               seg_d   = '0;
               ph_d    = PH_SETUP;
               bit_d   = '0;
               state_d = bus.rd_op ? ST_CAPTURE : ST_SHIFT;
            end
         end
         ST_CAPTURE: begin
            seg_d = seg_end ? '0 : seg_q + 1'b1;
            if (seg_end) begin
               ph_d = ph_q + 2'd1;
            end
            if (bit_end) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            seg_d = seg_end ? '0 : seg_q + 1'b1;
            if (seg_end) begin
               ph_d = ph_q + 2'd1;
            end
            // Sample late in setup so the synchronizer has settled since the last phib.
            if (seg_end && (ph_q == PH_SETUP)) begin
               shadow_d = {shadow_q[CHAIN_LEN-2:0], sync_q[1]};
            end
            if (bit_end) begin
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = rd_q ? ST_DONE : ST_LOAD_SU;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         ST_LOAD_SU: begin
            seg_d = seg_end ? '0 : seg_q + 1'b1;
            if (seg_end) begin
               state_d = ST_LOAD_HI;
            end
         end
         ST_LOAD_HI: begin
            seg_d = seg_end ? '0 : seg_q + 1'b1;
            if (seg_end) begin
               state_d = ST_LOAD_HD;
            end
         end
         ST_LOAD_HD: begin
            seg_d = seg_end ? '0 : seg_q + 1'b1;
            if (seg_end) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so each registered output lines up
      // with the state it belongs to.
      bit_start = (state_d == ST_SHIFT) && (ph_d == PH_SETUP) && (seg_d == '0);
      if (bit_start) begin
         scan_in_d = wreg_d[CHAIN_LEN-1];
         wreg_d    = {wreg_d[CHAIN_LEN-2:0], 1'b0};
      end else if ((state_d == ST_IDLE) || (state_d == ST_CAPTURE) || (state_d == ST_DONE)) begin
         scan_in_d = 1'b0;
      end

      if ((state_d == ST_DONE) && rd_q) begin
         rdata_d = shadow_q;
      end

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
      phi_d  = ((state_d == ST_CAPTURE) || (state_d == ST_SHIFT)) && (ph_d == PH_PHI);
      phib_d = ((state_d == ST_CAPTURE) || (state_d == ST_SHIFT)) && (ph_d == PH_PHIB);
      i0o1_d = (state_d == ST_CAPTURE);
      load_d = (state_d == ST_LOAD_HI);
   end

   assign bus.rdata     = rdata_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.phi       = phi_q;
   assign bus.phib      = phib_q;
   assign bus.scan_i0o1 = i0o1_q;
   assign bus.load      = load_q;
   assign bus.scan_in   = scan_in_q;

endmodule

// File: tb/tb_scan_master.sv
// Bench for scan_master: two instances (8x2 and 64x4) driving behavioural chip chains.
module tb_scan_master;
   localparam int LA = 8;
   localparam int PA = 2;
   localparam int LB = 64;
   localparam int PB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   scan_master_if #(.CHAIN_LEN(LA)) ifa ();
   scan_master_if #(.CHAIN_LEN(LB)) ifb ();

   scan_master #(.CHAIN_LEN(LA), .PHASE_CYC(PA)) dut_a (
      .clk_signal_ext (clk),
      .rst_n          (rst_n),
      .bus            (ifa.master)
   );
   scan_master #(.CHAIN_LEN(LB), .PHASE_CYC(PB)) dut_b (
      .clk_signal_ext (clk),
      .rst_n          (rst_n),
      .bus            (ifb.master)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Chip model: phib shifts (or captures the shadow when scan_i0o1), load copies chain to shadow.
   logic [LA-1:0] chain_a = '0, shad_a = '0, preset_val_a = '0;
   logic          preset_a = 1'b0;
   logic [LB-1:0] chain_b = '0, shad_b = '0;

   always @(posedge ifa.phib) chain_a <= ifa.scan_i0o1 ? shad_a : {chain_a[LA-2:0], ifa.scan_in};
   always @(posedge ifa.load or posedge preset_a) shad_a <= preset_a ? preset_val_a : chain_a;
   assign ifa.scan_out = chain_a[LA-1];

   always @(posedge ifb.phib) chain_b <= ifb.scan_i0o1 ? shad_b : {chain_b[LB-2:0], ifb.scan_in};
   always @(posedge ifb.load) shad_b <= chain_b;
   assign ifb.scan_out = chain_b[LB-1];

   int phi_run_a = 0, phib_run_a = 0, load_run_a = 0, gap_a = 0;
   int phi_cnt_a = 0, phib_cnt_a = 0, load_cnt_a = 0, i0o1_cyc_a = 0, done_cnt_a = 0;
   int phi_run_b = 0, phib_run_b = 0, load_run_b = 0;
   int phi_cnt_b = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         phi_run_a  = 0;
         phib_run_a = 0;
         load_run_a = 0;
         gap_a      = 0;
      end else begin
         chk("overlap_a", 64'(ifa.phi & ifa.phib), 64'(0));
         if (ifa.phib && phib_run_a == 0) chk("gap_a", 64'(gap_a >= PA), 64'(1));
         if (ifa.phi) gap_a = 0;
         else if (!ifa.phib) gap_a++;
         if (ifa.phi) phi_run_a++;
         else if (phi_run_a != 0) begin
            chk("phi_width_a", 64'(phi_run_a), 64'(PA));
            phi_run_a = 0;
            phi_cnt_a++;
         end
         if (ifa.phib) phib_run_a++;
         else if (phib_run_a != 0) begin
            chk("phib_width_a", 64'(phib_run_a), 64'(PA));
            phib_run_a = 0;
            phib_cnt_a++;
         end
         if (ifa.load) load_run_a++;
         else if (load_run_a != 0) begin
            chk("load_width_a", 64'(load_run_a), 64'(PA));
            load_run_a = 0;
            load_cnt_a++;
         end
         if (ifa.scan_i0o1) i0o1_cyc_a++;
         if (ifa.done) done_cnt_a++;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         phi_run_b  = 0;
         phib_run_b = 0;
         load_run_b = 0;
      end else begin
         chk("overlap_b", 64'(ifb.phi & ifb.phib), 64'(0));
         if (ifb.phi) phi_run_b++;
         else if (phi_run_b != 0) begin
            chk("phi_width_b", 64'(phi_run_b), 64'(PB));
            phi_run_b = 0;
            phi_cnt_b++;
         end
         if (ifb.phib) phib_run_b++;
         else if (phib_run_b != 0) begin
            chk("phib_width_b", 64'(phib_run_b), 64'(PB));
            phib_run_b = 0;
         end
         if (ifb.load) load_run_b++;
         else if (load_run_b != 0) begin
            chk("load_width_b", 64'(load_run_b), 64'(PB));
            load_run_b = 0;
         end
      end
   end

   // Runs one operation on the 8-bit instance; poke>0 pulses start during the op at that cycle.
   task automatic op_a(input bit rd, input logic [LA-1:0] d, input int poke,
                       output int lat, output int nphi, output int nphib,
                       output int nload, output int ni0o1);
      int p0, pb0, l0, s0;
      @(negedge clk);
      ifa.start = 1'b1;
      ifa.rd_op = rd;
      ifa.wdata = d;
      #1;
      p0 = phi_cnt_a; pb0 = phib_cnt_a; l0 = load_cnt_a; s0 = i0o1_cyc_a;
      @(negedge clk);
      ifa.start = 1'b0;
      ifa.rd_op = 1'($urandom);
      ifa.wdata = LA'($urandom);
      lat = 1;
      chk("busy_after_start_a", 64'(ifa.busy), 64'(1));
      while (!ifa.done && lat < 400) begin
         @(negedge clk);
         lat++;
         ifa.start = (lat == poke);
      end
      ifa.start = 1'b0;
      #1;
      nphi  = phi_cnt_a - p0;
      nphib = phib_cnt_a - pb0;
      nload = load_cnt_a - l0;
      ni0o1 = i0o1_cyc_a - s0;
   endtask

   task automatic op_b(input bit rd, input logic [LB-1:0] d, output int lat, output int nphi);
      int p0;
      @(negedge clk);
      ifb.start = 1'b1;
      ifb.rd_op = rd;
      ifb.wdata = d;
      #1;
      p0 = phi_cnt_b;
      @(negedge clk);
      ifb.start = 1'b0;
      ifb.rd_op = 1'($urandom);
      ifb.wdata = {$urandom, $urandom};
      lat = 1;
      while (!ifb.done && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
      #1;
      nphi = phi_cnt_b - p0;
   endtask

   initial begin
      int lat, nphi, nphib, nload, ni0o1, n, k, d0;
      logic prev;
      logic [LA-1:0] rd_prev, dw, ds;
      localparam int WLAT_A = LA * 4 * PA + 3 * PA + 1;
      localparam int RLAT_A = (LA + 1) * 4 * PA + 1;

      ifa.start = 1'b0; ifa.rd_op = 1'b0; ifa.wdata = '0;
      ifb.start = 1'b0; ifb.rd_op = 1'b0; ifb.wdata = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_phi_a",   64'(ifa.phi),       64'(0));
      chk("rst_phib_a",  64'(ifa.phib),      64'(0));
      chk("rst_i0o1_a",  64'(ifa.scan_i0o1), 64'(0));
      chk("rst_load_a",  64'(ifa.load),      64'(0));
      chk("rst_sin_a",   64'(ifa.scan_in),   64'(0));
      chk("rst_busy_a",  64'(ifa.busy),      64'(0));
      chk("rst_done_a",  64'(ifa.done),      64'(0));
      chk("rst_rdata_a", 64'(ifa.rdata),     64'(0));
      chk("rst_rdata_b", ifb.rdata,          64'(0));
      rst_n = 1'b1;

      // Reset in the middle of bit 3 while phi is high; 5A puts a 1 on scan_in there.
      @(negedge clk);
      ifa.start = 1'b1; ifa.rd_op = 1'b0; ifa.wdata = 8'h5A;
      @(negedge clk);
      ifa.start = 1'b0;
      n = 0; k = 0; prev = 1'b0;
      while (n < 4 && k < 200) begin
         @(negedge clk);
         k++;
         if (ifa.phi && !prev) n++;
         prev = ifa.phi;
      end
      chk("pre_rst_phi",  64'(ifa.phi),     64'(1));
      chk("pre_rst_sin",  64'(ifa.scan_in), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_phi",   64'(ifa.phi),     64'(0));
      chk("async_rst_sin",   64'(ifa.scan_in), 64'(0));
      chk("async_rst_busy",  64'(ifa.busy),    64'(0));
      chk("async_rst_rdata", 64'(ifa.rdata),   64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      op_a(1'b0, 8'hA5, 0, lat, nphi, nphib, nload, ni0o1);
      chk("wr_lat",   64'(lat),   64'(WLAT_A));
      chk("wr_phi",   64'(nphi),  64'(LA));
      chk("wr_phib",  64'(nphib), 64'(LA));
      chk("wr_load",  64'(nload), 64'(1));
      chk("wr_i0o1",  64'(ni0o1), 64'(0));
      chk("wr_shad",  64'(shad_a), 64'(8'hA5));
      chk("wr_done",  64'(ifa.done), 64'(1));
      chk("wr_rdata", 64'(ifa.rdata), 64'(0));

      preset_val_a = 8'h3C;
      preset_a = 1'b1;
      #1 preset_a = 1'b0;
      op_a(1'b1, 8'h00, 0, lat, nphi, nphib, nload, ni0o1);
      chk("rd_lat",   64'(lat),   64'(RLAT_A));
      chk("rd_phi",   64'(nphi),  64'(LA + 1));
      chk("rd_load",  64'(nload), 64'(0));
      chk("rd_i0o1",  64'(ni0o1), 64'(4 * PA));
      chk("rd_rdata", 64'(ifa.rdata), 64'(8'h3C));
      chk("rd_busy",  64'(ifa.busy),  64'(0));
      chk("rd_done",  64'(ifa.done),  64'(1));

      // Back-to-back with an ignored start during the write.
      #1 d0 = done_cnt_a;
      op_a(1'b0, 8'hFF, 10, lat, nphi, nphib, nload, ni0o1);
      chk("b2b_wr_lat",   64'(lat), 64'(WLAT_A));
      chk("b2b_wr_rdata", 64'(ifa.rdata), 64'(8'h3C));
      op_a(1'b1, 8'h00, 0, lat, nphi, nphib, nload, ni0o1);
      chk("b2b_rd_lat",   64'(lat), 64'(RLAT_A));
      chk("b2b_rd_rdata", 64'(ifa.rdata), 64'(8'hFF));
      repeat (20) @(negedge clk);
      #1;
      chk("b2b_done_cnt", 64'(done_cnt_a - d0), 64'(2));
      chk("b2b_idle_busy", 64'(ifa.busy), 64'(0));

      rd_prev = 8'hFF;
      for (int i = 0; i < 6; i++) begin
         dw = LA'($urandom);
         op_a(1'b0, dw, 0, lat, nphi, nphib, nload, ni0o1);
         chk("rnd_wr_shad",  64'(shad_a), 64'(dw));
         chk("rnd_wr_rdata", 64'(ifa.rdata), 64'(rd_prev));
         ds = LA'($urandom);
         preset_val_a = ds;
         preset_a = 1'b1;
         #1 preset_a = 1'b0;
         op_a(1'b1, LA'($urandom), 0, lat, nphi, nphib, nload, ni0o1);
         chk("rnd_rd_rdata", 64'(ifa.rdata), 64'(ds));
         chk("rnd_rd_lat",   64'(lat), 64'(RLAT_A));
         rd_prev = ds;
      end

      op_b(1'b0, 64'h0123_4567_89AB_CDEF, lat, nphi);
      chk("b_wr_lat",  64'(lat),  64'(LB * 4 * PB + 3 * PB + 1));
      chk("b_wr_phi",  64'(nphi), 64'(LB));
      chk("b_wr_shad", shad_b,    64'h0123_4567_89AB_CDEF);
      op_b(1'b1, 64'h0, lat, nphi);
      chk("b_rd_lat",   64'(lat),  64'((LB + 1) * 4 * PB + 1));
      chk("b_rd_phi",   64'(nphi), 64'(LB + 1));
      chk("b_rd_rdata", ifb.rdata, 64'h0123_4567_89AB_CDEF);
      chk("b_rd_busy",  64'(ifb.busy), 64'(0));

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
